// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipeline_hazard_ctrl_pkg;

  localparam int REG_W = 4;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

  // Control fields a latch loads when it is turned into a NOP (bubble or flush).
  typedef struct packed {
    logic write;
    logic read_mem;
    logic write_mem;
  } ex_ctrl_t;

  localparam ex_ctrl_t NOP_CTRL = '{write: 1'b0, read_mem: 1'b0, write_mem: 1'b0};

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_compare.sv
// Load-use comparator: flags an ID source that matches the destination of a load in EX.
module hazard_compare #(
  parameter int REG_W = 4
) (
  input  logic [REG_W-1:0] read_reg0,
  input  logic [REG_W-1:0] read_reg1,
  input  logic             use0,
  input  logic             use1,
  input  logic             ex_write,
  input  logic             ex_read_mem,
  input  logic [REG_W-1:0] ex_write_reg,
  output logic             hazard
);

  assign hazard = ex_write & ex_read_mem &
                  ((use0 & (read_reg0 == ex_write_reg)) |
                   (use1 & (read_reg1 == ex_write_reg)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the IF/ID/EX/MEM pipeline: load-use bubbles,
// data-memory wait freezes with timeout, and taken-branch flushes.
module pipeline_hazard_ctrl #(
  parameter int REG_W        = pipeline_hazard_ctrl_pkg::REG_W,
  parameter int LOAD_BUBBLES = 1,
  parameter int MEM_TIMEOUT  = 64,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_readReg0,
  input  logic [REG_W-1:0] id_readReg1,
  input  logic             id_use0,
  input  logic             id_use1,
  input  logic             ex_write,
  input  logic [REG_W-1:0] ex_writeReg,
  input  logic             ex_ReadMem,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             branch_taken,
  output logic             pc_hold,
  output logic             stall_if_id,
  output logic             stall_id_ex,
  output logic             bubble_id_ex,
  output logic             stall_ex_mem,
  output logic             flush_if_id,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);
  import pipeline_hazard_ctrl_pkg::*;

  localparam int              TO_W     = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_MAX   = TO_W'(MEM_TIMEOUT);
  localparam logic [1:0]      LB_EXTRA = 2'(LOAD_BUBBLES - 1);

  state_e            state_q, state_d;
  logic [1:0]        bub_cnt_q, bub_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;

  logic hazard_lu;
  logic mem_stall;
  logic freeze, lu_hold, bubble, flush;

  hazard_compare #(.REG_W(REG_W)) u_hazard_compare (
    .read_reg0   (id_readReg0),
    .read_reg1   (id_readReg1),
    .use0        (id_use0),
    .use1        (id_use1),
    .ex_write    (ex_write),
    .ex_read_mem (ex_ReadMem),
    .ex_write_reg(ex_writeReg),
    .hazard      (hazard_lu)
  );

  assign mem_stall = mem_req & ~mem_ready;

  always_comb begin
    state_d       = state_q;
    bub_cnt_d     = bub_cnt_q;
    to_cnt_d      = to_cnt_q;
    mem_timeout_d = mem_timeout_q;
    freeze        = 1'b0;
    lu_hold       = 1'b0;
    bubble        = 1'b0;
    flush         = 1'b0;

    case (state_q)
      MEM_WAIT: begin
        // The ready cycle stays frozen; a timeout releases without freezing.
        if (mem_ready) begin
          freeze   = 1'b1;
          state_d  = RUN;
          to_cnt_d = '0;
        end else if (to_cnt_q == TO_MAX) begin
          mem_timeout_d = 1'b1;
          state_d       = RUN;
          to_cnt_d      = '0;
        end else begin
          freeze   = 1'b1;
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      LU_STALL: begin
        if (mem_stall) begin
          freeze    = 1'b1;
          state_d   = MEM_WAIT;
          to_cnt_d  = TO_W'(1);
          bub_cnt_d = '0;
        end else if (branch_taken) begin
          flush     = 1'b1;
          bubble    = 1'b1;
          state_d   = RUN;
          bub_cnt_d = '0;
        end else begin
          lu_hold   = 1'b1;
          bubble    = 1'b1;
          bub_cnt_d = bub_cnt_q - 2'd1;
          if (bub_cnt_q == 2'd1) state_d = RUN;
        end
      end

      default: begin
        if (mem_stall) begin
          freeze   = 1'b1;
          state_d  = MEM_WAIT;
          to_cnt_d = TO_W'(1);
        end else if (branch_taken) begin
          flush  = 1'b1;
          bubble = 1'b1;
        end else if (hazard_lu) begin
          lu_hold = 1'b1;
          bubble  = 1'b1;
          if (LOAD_BUBBLES > 1) begin
            state_d   = LU_STALL;
            bub_cnt_d = LB_EXTRA;
          end
        end
      end
    endcase
  end

  always_comb begin
    pc_hold      = ~rst & (freeze | lu_hold);
    stall_if_id  = ~rst & (freeze | lu_hold);
    stall_id_ex  = ~rst & freeze;
    stall_ex_mem = ~rst & freeze;
    bubble_id_ex = ~rst & bubble;
    flush_if_id  = ~rst & flush;

    stall_cycles_d = stall_cycles_q;
    if (pc_hold && !(&stall_cycles_q)) stall_cycles_d = stall_cycles_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      bub_cnt_q      <= '0;
      to_cnt_q       <= '0;
      mem_timeout_q  <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      bub_cnt_q      <= bub_cnt_d;
      to_cnt_q       <= to_cnt_d;
      mem_timeout_q  <= mem_timeout_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign mem_timeout  = mem_timeout_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: two instances (1 and 2 load bubbles, wide and narrow counters)
// driven identically and compared against a count-based reference model.
module tb_pipeline_hazard_ctrl;

  localparam int TIMEOUT = 64;
  localparam int CNT_W_B = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] id_readReg0, id_readReg1, ex_writeReg;
  logic id_use0, id_use1, ex_write, ex_ReadMem, mem_req, mem_ready, branch_taken;

  logic a_pc_hold, a_stall_if_id, a_stall_id_ex, a_bubble, a_stall_ex_mem, a_flush, a_timeout;
  logic b_pc_hold, b_stall_if_id, b_stall_id_ex, b_bubble, b_stall_ex_mem, b_flush, b_timeout;
  logic [15:0]        a_cycles;
  logic [CNT_W_B-1:0] b_cycles;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_W(4), .LOAD_BUBBLES(1), .MEM_TIMEOUT(TIMEOUT), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst),
    .id_readReg0(id_readReg0), .id_readReg1(id_readReg1), .id_use0(id_use0), .id_use1(id_use1),
    .ex_write(ex_write), .ex_writeReg(ex_writeReg), .ex_ReadMem(ex_ReadMem),
    .mem_req(mem_req), .mem_ready(mem_ready), .branch_taken(branch_taken),
    .pc_hold(a_pc_hold), .stall_if_id(a_stall_if_id), .stall_id_ex(a_stall_id_ex),
    .bubble_id_ex(a_bubble), .stall_ex_mem(a_stall_ex_mem), .flush_if_id(a_flush),
    .mem_timeout(a_timeout), .stall_cycles(a_cycles)
  );

  pipeline_hazard_ctrl #(.REG_W(4), .LOAD_BUBBLES(2), .MEM_TIMEOUT(TIMEOUT), .CNT_W(CNT_W_B)) dut_b (
    .clk(clk), .rst(rst),
    .id_readReg0(id_readReg0), .id_readReg1(id_readReg1), .id_use0(id_use0), .id_use1(id_use1),
    .ex_write(ex_write), .ex_writeReg(ex_writeReg), .ex_ReadMem(ex_ReadMem),
    .mem_req(mem_req), .mem_ready(mem_ready), .branch_taken(branch_taken),
    .pc_hold(b_pc_hold), .stall_if_id(b_stall_if_id), .stall_id_ex(b_stall_id_ex),
    .bubble_id_ex(b_bubble), .stall_ex_mem(b_stall_ex_mem), .flush_if_id(b_flush),
    .mem_timeout(b_timeout), .stall_cycles(b_cycles)
  );

  typedef struct packed {
    logic [3:0] rr0, rr1;
    logic       use0, use1, ex_write;
    logic [3:0] ewr;
    logic       ex_rd, mem_req, mem_ready, branch;
  } stim_t;

  typedef struct packed {
    logic        pc_hold, stall_if_id, stall_id_ex, bubble, stall_ex_mem, flush, timeout;
    logic [15:0] cycles;
  } exp_t;

  typedef struct packed {
    exp_t a;
    exp_t b;
  } sb_t;

  sb_t sb_q[$];
  int  vectors = 0;
  int  miscompares = 0;

  // Reference model state per instance: bubbles still owed, wait length so far.
  int lu_left[2] = '{0, 0};
  bit waiting[2] = '{0, 0};
  int frozen[2]  = '{0, 0};
  bit sticky[2]  = '{0, 0};
  int stalls[2]  = '{0, 0};
  int lb[2]      = '{1, 2};
  int cmax[2]    = '{65535, 63};

  function automatic exp_t model_step(input int k, input stim_t s, input logic r);
    exp_t e;
    bit hz, freeze, lu, bub, fl;
    e = '0;
    e.timeout = sticky[k];
    e.cycles  = 16'(stalls[k]);
    if (r) begin
      lu_left[k] = 0; waiting[k] = 0; frozen[k] = 0; sticky[k] = 0; stalls[k] = 0;
      return e;
    end
    hz = s.ex_write && s.ex_rd &&
         ((s.use0 && s.rr0 == s.ewr) || (s.use1 && s.rr1 == s.ewr));
    freeze = 0; lu = 0; bub = 0; fl = 0;
    if (waiting[k]) begin
      if (s.mem_ready) begin
        freeze = 1; waiting[k] = 0;
      end else if (frozen[k] == TIMEOUT) begin
        sticky[k] = 1; waiting[k] = 0;
      end else begin
        freeze = 1; frozen[k]++;
      end
    end else if (s.mem_req && !s.mem_ready) begin
      freeze = 1; waiting[k] = 1; frozen[k] = 1; lu_left[k] = 0;
    end else if (s.branch) begin
      fl = 1; bub = 1; lu_left[k] = 0;
    end else if (lu_left[k] > 0) begin
      lu = 1; bub = 1; lu_left[k]--;
    end else if (hz) begin
      lu = 1; bub = 1; lu_left[k] = lb[k] - 1;
    end
    e.pc_hold      = freeze | lu;
    e.stall_if_id  = freeze | lu;
    e.stall_id_ex  = freeze;
    e.stall_ex_mem = freeze;
    e.bubble       = bub;
    e.flush        = fl;
    if (e.pc_hold && stalls[k] < cmax[k]) stalls[k]++;
    return e;
  endfunction

  function automatic stim_t mk(input int rr0, input int rr1, input bit u0, input bit u1,
                               input bit ew, input int ewr, input bit erd,
                               input bit mq, input bit mr, input bit br);
    stim_t s;
    s.rr0 = 4'(rr0); s.rr1 = 4'(rr1); s.use0 = u0; s.use1 = u1; s.ex_write = ew;
    s.ewr = 4'(ewr); s.ex_rd = erd; s.mem_req = mq; s.mem_ready = mr; s.branch = br;
    return s;
  endfunction

  task automatic apply_stimulus(input stim_t s, input logic r);
    sb_t entry;
    id_readReg0 = s.rr0; id_readReg1 = s.rr1; id_use0 = s.use0; id_use1 = s.use1;
    ex_write = s.ex_write; ex_writeReg = s.ewr; ex_ReadMem = s.ex_rd;
    mem_req = s.mem_req; mem_ready = s.mem_ready; branch_taken = s.branch;
    rst = r;
    entry.a = model_step(0, s, r);
    entry.b = model_step(1, s, r);
    sb_q.push_back(entry);
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input exp_t act, input exp_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s vector %0d at %0t: got ph=%b sif=%b sie=%b bub=%b sem=%b fl=%b to=%b cyc=%0d, want ph=%b sif=%b sie=%b bub=%b sem=%b fl=%b to=%b cyc=%0d",
               name, vectors, $time,
               act.pc_hold, act.stall_if_id, act.stall_id_ex, act.bubble, act.stall_ex_mem, act.flush, act.timeout, act.cycles,
               exp.pc_hold, exp.stall_if_id, exp.stall_id_ex, exp.bubble, exp.stall_ex_mem, exp.flush, exp.timeout, exp.cycles);
    end
  endtask

  // Monitor: outputs are combinational, so each pushed cycle is sampled mid-cycle.
  initial begin
    sb_t  e;
    exp_t act_a, act_b;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        act_a = {a_pc_hold, a_stall_if_id, a_stall_id_ex, a_bubble, a_stall_ex_mem, a_flush, a_timeout, a_cycles};
        act_b = {b_pc_hold, b_stall_if_id, b_stall_id_ex, b_bubble, b_stall_ex_mem, b_flush, b_timeout,
                 {(16-CNT_W_B)'(0), b_cycles}};
        check_output("lb1", act_a, e.a);
        check_output("lb2", act_b, e.b);
      end
    end
  end

  initial begin
    stim_t idle, s;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    id_readReg0 = '0; id_readReg1 = '0; id_use0 = 0; id_use1 = 0; ex_write = 0;
    ex_writeReg = '0; ex_ReadMem = 0; mem_req = 0; mem_ready = 0; branch_taken = 0;
    repeat (2) @(posedge clk);
    #1;
    apply_stimulus(idle, 1'b1);

    // Load r3 in EX, ID reads r3; then the load moves on
    apply_stimulus(mk(3, 5, 1, 1, 1, 3, 1, 0, 0, 0), 1'b0);
    apply_stimulus(mk(3, 5, 1, 1, 0, 0, 0, 0, 0, 0), 1'b0);
    apply_stimulus(idle, 1'b0);
    // Unused source and non-writing EX must not stall
    apply_stimulus(mk(1, 3, 1, 0, 1, 3, 1, 0, 0, 0), 1'b0);
    apply_stimulus(mk(3, 3, 1, 1, 0, 3, 1, 0, 0, 0), 1'b0);
    // Memory wait of five cycles, then ready
    repeat (5) apply_stimulus(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 1'b0);
    apply_stimulus(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0), 1'b0);
    apply_stimulus(idle, 1'b0);
    // Branch beats load-use; memory stall beats branch
    apply_stimulus(mk(3, 5, 1, 1, 1, 3, 1, 0, 0, 1), 1'b0);
    apply_stimulus(mk(3, 5, 1, 1, 1, 3, 1, 1, 0, 1), 1'b0);
    apply_stimulus(mk(3, 5, 1, 1, 1, 3, 1, 1, 1, 1), 1'b0);
    apply_stimulus(mk(3, 5, 1, 1, 1, 3, 1, 0, 0, 1), 1'b0);
    apply_stimulus(idle, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      s.rr0       = 4'($urandom_range(0, 3));
      s.rr1       = 4'($urandom_range(0, 3));
      s.use0      = 1'($urandom);
      s.use1      = 1'($urandom);
      s.ex_write  = 1'($urandom);
      s.ewr       = 4'($urandom_range(0, 3));
      s.ex_rd     = 1'($urandom);
      s.mem_req   = ($urandom_range(0, 2) == 0);
      s.mem_ready = ($urandom_range(0, 2) != 0);
      s.branch    = ($urandom_range(0, 7) == 0);
      apply_stimulus(s, ($urandom_range(0, 199) == 0));
    end

    // Memory never answers: timeout, sticky flag, re-entry while still requesting
    repeat (70) apply_stimulus(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 1'b0);
    repeat (4) apply_stimulus(idle, 1'b0);
    // Reset in the middle of a wait clears everything
    repeat (3) apply_stimulus(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 1'b0);
    apply_stimulus(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 1'b1);
    repeat (3) apply_stimulus(idle, 1'b0);

    repeat (3) @(posedge clk);
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: %0d entries left, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
